mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- M-stage load/store unit, directly upstream of the MEM/WB pipeline register.
- Turns the M-stage memory op into a request/acknowledge bus transaction with byte enables and store-data lane replication.
- Returns a sign/zero-extended load result that feeds M_DR.
- Stalls the pipeline while the bus is busy and reports address exceptions to CP0.

Parameters:
- TIMEOUT_CYC, 16: BUSY cycles without bus_ack before a bus-error exception. Used only with LSU_TIMEOUT_EN; range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m_valid  in  1  M-stage instruction valid
- m_op  in  4  memory op code; see Decomposition
- m_addr  in  32  effective address from ALU
- m_wdata  in  32  store data (rt), already forwarded
- flush  in  1  kill current M instruction (exception/eret)
- stall  out  1  freeze F..M stages and hold MW_REG write enable low
- m_dr  out  32  extended load data to MEM/WB
- done  out  1  one-cycle pulse: bus transaction finished
- exc  out  1  exception request to CP0
- exc_code  out  5  4=AdEL, 5=AdES, 7=DBE
- bus_req  out  1  bus request, registered
- bus_we  out  1  write transaction
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion; for reads, rdata is valid in the same cycle
- bus_rdata  in  32  read data

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, m_dr, done, exc, exc_code and timeout counter all 0.
- A request is m_valid & m_op!=NONE & !flush.
- Alignment faults:
  - Loads: LW with addr[1:0]!=0, LH/LHU with addr[0]!=0 → exc=1, exc_code=4.
  - Stores: SW with addr[1:0]!=0, SH with addr[0]!=0 → exc=1, exc_code=5.
  - A fault is combinational in IDLE, issues no bus request and does not stall.
- IDLE with an aligned request:
  - At the next edge, register bus_addr/be/we/wdata and the op/addr[1:0] for extension.
  - Set bus_req=1 and move to BUSY.
  - stall is high combinationally in this same cycle.
- BUSY:
  - stall=1 and bus_req is held.
  - On bus_ack at edge t: drop bus_req; capture the extended rdata into m_dr (loads only; stores leave m_dr unchanged); go to DONE.
  - Minimum load latency is 2 cycles from request to done.
- DONE:
  - done=1 and stall=0, so the pipeline advances at the end of this cycle.
  - No new request is accepted; the instruction seen in DONE is the completed one.
  - Return to IDLE.
- Byte enables and store data:
  - SW: be=1111.
  - SH: be=1100 if addr[1] else 0011; wdata={h,h}.
  - SB: be=0001<<addr[1:0]; wdata={b,b,b,b}.
  - Loads: be=1111.
- Load extension selects the lane by the captured addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Flush in BUSY:
  - The transaction is not aborted; bus_req is held until bus_ack.
  - A kill flag is set: m_dr is not updated, done stays 0, and the FSM goes straight back to IDLE.
  - stall stays high until ack.
- Flush in IDLE: no request and no exc.
- Reset in BUSY: immediate return to IDLE with bus_req=0. The bus must tolerate the dropped request.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8-bit counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYC: drop bus_req, go to DONE with m_dr=0, exc=1, exc_code=7.
  - Ack in the same cycle as the limit wins; no exception is raised.
- Undefined: BUSY waits indefinitely for bus_ack; the counter and exc_code 7 do not exist.

Decomposition:
- Shared constants in const.v:
  - Op codes NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8.
  - Exception codes AdEL=4, AdES=5, DBE=7.
  - State encodings.
- One combinational sub-module, lsu_data_ext: inputs op, addr[1:0], rdata; output extended data.

Test Plan:
- LW addr 0x0000_1004, ack after 3 BUSY cycles, rdata 0xDEADBEEF → stall high 4 cycles, done pulse, m_dr=0xDEADBEEF, bus_be=1111.
- LB addr 0x...1003 with rdata 0x80FF_7F01 → m_dr=0xFFFFFF80; LBU same → 0x00000080; LH addr 0x...1002 → 0xFFFF80FF.
- SH addr 0x...2002, wdata 0x1234ABCD → bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x...2000.
- LW addr 0x...1001 → exc=1, exc_code=4, bus_req never asserts, stall=0; SH addr 0x...3 → exc_code=5.
- Flush asserted during BUSY, ack 2 cycles later → m_dr unchanged, done stays 0, stall falls after ack, FSM in IDLE.
- LSU_TIMEOUT_EN, TIMEOUT_CYC=4, no ack → bus_req drops after 4 BUSY cycles, exc=1, exc_code=7, m_dr=0.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants for the M-stage load/store unit: op codes, CP0 exception codes,
// FSM state encoding and small op-classification helpers.
package mem_stage_lsu_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LBU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SB);
    endfunction

    // Byte accesses can never fault; word and half accesses need natural alignment.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lane);
        case (op)
            OP_LW, OP_SW:         return lane != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lane[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_data_ext.sv
// Load-data lane select and sign/zero extension for the M-stage LSU.
module mem_stage_lsu_data_ext
    import mem_stage_lsu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_lane)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        case (i_op)
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'h0000, w_half};
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'h000000, w_byte};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: req/ack bus master with byte enables, load extension,
// pipeline stall and address/bus exceptions. LSU_TIMEOUT_EN adds a bus-error timeout.
// Bus handshake: bus_req is registered and held high until the cycle bus_ack is
// sampled high; bus_rdata is valid in that same ack cycle.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [3:0]  m_op,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] m_dr,
  output logic        done,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  o_dbg_state
);
  import mem_stage_lsu_pkg::*;

  lsu_state_t  r_state;
  logic [3:0]  r_op;
  logic [1:0]  r_lane;
  logic        r_kill;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_dr;
  logic        r_done;
  logic        r_exc;
  logic [4:0]  r_exc_code;
`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  assign w_cnt_nxt = r_cnt + 8'd1;
`endif

  logic        w_req;
  logic        w_fault;
  logic        w_start;
  logic        w_kill;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  assign w_req   = m_valid && (op_is_load(m_op) || op_is_store(m_op)) && !flush;
  assign w_fault = (r_state == ST_IDLE) && w_req && op_misaligned(m_op, m_addr[1:0]);
  assign w_start = (r_state == ST_IDLE) && w_req && !op_misaligned(m_op, m_addr[1:0]);
  // A flush landing in the ack cycle must also suppress the writeback.
  assign w_kill  = r_kill || flush;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = m_wdata;
    case (m_op)
      OP_SH: begin
        w_be    = m_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{m_wdata[15:0]}};
      end
      OP_SB: begin
        w_be    = 4'b0001 << m_addr[1:0];
        w_wdata = {4{m_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  mem_stage_lsu_data_ext u_ext (
    .i_op    (r_op),
    .i_lane  (r_lane),
    .i_rdata (bus_rdata),
    .o_data  (w_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_NONE;
      r_lane     <= 2'b00;
      r_kill     <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'h0;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0;
      r_dr       <= 32'h0;
      r_done     <= 1'b0;
      r_exc      <= 1'b0;
      r_exc_code <= 5'd0;
`ifdef LSU_TIMEOUT_EN
      r_cnt      <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_BUSY;
            r_req   <= 1'b1;
            r_we    <= op_is_store(m_op);
            r_addr  <= {m_addr[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_op    <= m_op;
            r_lane  <= m_addr[1:0];
            r_kill  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_cnt   <= 8'd0;
`endif
          end
        end
        ST_BUSY: begin
          if (flush) r_kill <= 1'b1;
          if (bus_ack) begin
            r_req <= 1'b0;
            if (w_kill) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              if (!r_we) r_dr <= w_ext;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (w_cnt_nxt == TIMEOUT_LIM) begin
            r_req <= 1'b0;
            r_cnt <= w_cnt_nxt;
            if (w_kill) begin
              r_state <= ST_IDLE;
            end else begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_dr       <= 32'h0;
              r_exc      <= 1'b1;
              r_exc_code <= EXC_DBE;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
          end
`endif
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_done     <= 1'b0;
          r_exc      <= 1'b0;
          r_exc_code <= 5'd0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall       = (r_state == ST_BUSY) || w_start;
  assign exc         = w_fault || r_exc;
  assign exc_code    = w_fault ? (op_is_load(m_op) ? EXC_ADEL : EXC_ADES) : r_exc_code;
  assign done        = r_done;
  assign m_dr        = r_dr;
  assign bus_req     = r_req;
  assign bus_we      = r_we;
  assign bus_addr    = r_addr;
  assign bus_be      = r_be;
  assign bus_wdata   = r_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed + randomised bench for mem_stage_lsu with an expected-load-data queue.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [3:0]  m_op;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        flush;
  logic        stall;
  logic [31:0] m_dr;
  logic        done;
  logic        exc;
  logic [4:0]  exc_code;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  logic [31:0] model_dr;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_op(m_op), .m_addr(m_addr),
    .m_wdata(m_wdata), .flush(flush), .stall(stall), .m_dr(m_dr), .done(done),
    .exc(exc), .exc_code(exc_code), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .o_dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ext_model(input logic [3:0] op, input logic [1:0] lane,
                                            input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * lane);
    case (op)
      OP_LB:   return {{24{sh[7]}}, sh[7:0]};
      OP_LBU:  return {24'h0, sh[7:0]};
      OP_LH:   return {{16{sh[15]}}, sh[15:0]};
      OP_LHU:  return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  task automatic run_txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int ack_wait,
                         input logic [31:0] exp_dr, input logic exp_we,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int          stall_cyc;
    logic [31:0] exp_v;
    stall_cyc = 0;
    exp_q.push_back(exp_dr);
    m_valid = 1'b1; m_op = op; m_addr = addr; m_wdata = wdata;
    @(negedge clk);
    check($sformatf("%s.req_in_idle", tag), 32'(bus_req), 32'd0);
    if (stall) stall_cyc++;
    step();
    for (int k = 1; k <= ack_wait; k++) begin
      if (k == ack_wait) begin
        bus_ack = 1'b1; bus_rdata = rdata;
      end
      @(negedge clk);
      if (stall) stall_cyc++;
      if (k == 1) begin
        check($sformatf("%s.bus_req", tag), 32'(bus_req), 32'd1);
        check($sformatf("%s.bus_we", tag), 32'(bus_we), 32'(exp_we));
        check($sformatf("%s.bus_be", tag), 32'(bus_be), 32'(exp_be));
        check($sformatf("%s.bus_addr", tag), bus_addr, {addr[31:2], 2'b00});
        if (exp_we) check($sformatf("%s.bus_wdata", tag), bus_wdata, exp_wdata);
      end
      step();
    end
    bus_ack = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    check($sformatf("%s.done", tag), 32'(done), 32'd1);
    check($sformatf("%s.stall_done", tag), 32'(stall), 32'd0);
    check($sformatf("%s.req_dropped", tag), 32'(bus_req), 32'd0);
    check($sformatf("%s.stall_cycles", tag), 32'(stall_cyc), 32'(ack_wait + 1));
    exp_v = exp_q.pop_front();
    if (done === 1'b1) check($sformatf("%s.m_dr", tag), m_dr, exp_v);
    m_valid = 1'b0; m_op = OP_NONE;
    step();
    @(negedge clk);
    check($sformatf("%s.done_pulse", tag), 32'(done), 32'd0);
    step();
  endtask

  task automatic fault_case(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [4:0] code);
    m_valid = 1'b1; m_op = op; m_addr = addr; m_wdata = $urandom;
    @(negedge clk);
    check($sformatf("%s.exc", tag), 32'(exc), 32'd1);
    check($sformatf("%s.exc_code", tag), 32'(exc_code), 32'(code));
    check($sformatf("%s.stall", tag), 32'(stall), 32'd0);
    step();
    @(negedge clk);
    check($sformatf("%s.no_req", tag), 32'(bus_req), 32'd0);
    m_valid = 1'b0; m_op = OP_NONE;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r_op;
    logic [1:0]  r_lane;
    logic [31:0] r_rd;
    logic [31:0] ops [5];

    reset = 1'b1; m_valid = 1'b0; m_op = OP_NONE; m_addr = 32'h0; m_wdata = 32'h0;
    flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    model_dr = 32'h0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst.bus_req", 32'(bus_req), 32'd0);
    check("rst.bus_we", 32'(bus_we), 32'd0);
    check("rst.bus_be", 32'(bus_be), 32'd0);
    check("rst.bus_addr", bus_addr, 32'd0);
    check("rst.bus_wdata", bus_wdata, 32'd0);
    check("rst.m_dr", m_dr, 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.exc", 32'(exc), 32'd0);
    check("rst.exc_code", 32'(exc_code), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.state", 32'(dbg_state), 32'd0);
    step();

    // Directed loads and stores from the test plan.
    model_dr = 32'hDEADBEEF;
    run_txn("lw", OP_LW, 32'h0000_1004, 32'h0, 32'hDEADBEEF, 3, model_dr, 1'b0, 4'b1111, 32'h0);
    model_dr = 32'hFFFFFF80;
    run_txn("lb", OP_LB, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 1, model_dr, 1'b0, 4'b1111, 32'h0);
    model_dr = 32'h00000080;
    run_txn("lbu", OP_LBU, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 2, model_dr, 1'b0, 4'b1111, 32'h0);
    model_dr = 32'hFFFF80FF;
    run_txn("lh", OP_LH, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 1, model_dr, 1'b0, 4'b1111, 32'h0);
    model_dr = 32'h00007F01;
    run_txn("lhu", OP_LHU, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 1, model_dr, 1'b0, 4'b1111, 32'h0);
    model_dr = 32'h0000007F;
    run_txn("lb1", OP_LB, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 1, model_dr, 1'b0, 4'b1111, 32'h0);
    run_txn("sh", OP_SH, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 2, model_dr, 1'b1, 4'b1100, 32'hABCD_ABCD);
    run_txn("sh_lo", OP_SH, 32'h0000_2000, 32'h1234_ABCD, 32'h0, 1, model_dr, 1'b1, 4'b0011, 32'hABCD_ABCD);
    run_txn("sb", OP_SB, 32'h0000_2001, 32'h0000_00CD, 32'h0, 1, model_dr, 1'b1, 4'b0010, 32'hCDCD_CDCD);
    run_txn("sb3", OP_SB, 32'h0000_2003, 32'h5555_5A12, 32'h0, 1, model_dr, 1'b1, 4'b1000, 32'h1212_1212);
    run_txn("sw", OP_SW, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 3, model_dr, 1'b1, 4'b1111, 32'hCAFE_F00D);

    // Address faults.
    fault_case("lw_mis", OP_LW, 32'h0000_1001, EXC_ADEL);
    fault_case("lh_mis", OP_LH, 32'h0000_1003, EXC_ADEL);
    fault_case("sh_mis", OP_SH, 32'h0000_2003, EXC_ADES);
    fault_case("sw_mis", OP_SW, 32'h0000_2002, EXC_ADES);

    // Flush in IDLE on a misaligned load: neither request nor exception.
    m_valid = 1'b1; m_op = OP_LW; m_addr = 32'h0000_1001; flush = 1'b1;
    @(negedge clk);
    check("flush_idle.exc", 32'(exc), 32'd0);
    check("flush_idle.stall", 32'(stall), 32'd0);
    step();
    @(negedge clk);
    check("flush_idle.no_req", 32'(bus_req), 32'd0);
    m_valid = 1'b0; m_op = OP_NONE; flush = 1'b0;
    step();

    // Flush during BUSY, ack two cycles later.
    m_valid = 1'b1; m_op = OP_LW; m_addr = 32'h0000_1008;
    step();
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy.stall1", 32'(stall), 32'd1);
    step();
    flush = 1'b0; m_valid = 1'b0; m_op = OP_NONE;
    @(negedge clk);
    check("flush_busy.stall2", 32'(stall), 32'd1);
    check("flush_busy.req_held", 32'(bus_req), 32'd1);
    step();
    bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    check("flush_busy.stall3", 32'(stall), 32'd1);
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    check("flush_busy.stall_low", 32'(stall), 32'd0);
    check("flush_busy.no_done", 32'(done), 32'd0);
    check("flush_busy.idle", 32'(dbg_state), 32'(ST_IDLE));
    check("flush_busy.m_dr", m_dr, model_dr);
    check("flush_busy.req_low", 32'(bus_req), 32'd0);
    step();
    @(negedge clk);
    check("flush_busy.no_done2", 32'(done), 32'd0);
    step();

    // Randomised aligned loads checked against an independent extension model.
    ops = '{32'(OP_LW), 32'(OP_LH), 32'(OP_LHU), 32'(OP_LB), 32'(OP_LBU)};
    for (int i = 0; i < 6; i++) begin
      r_op   = ops[$urandom_range(0, 4)][3:0];
      r_lane = 2'($urandom_range(0, 3));
      if (r_op == OP_LW) r_lane = 2'b00;
      else if (r_op == OP_LH || r_op == OP_LHU) r_lane[0] = 1'b0;
      r_rd = $urandom;
      model_dr = ext_model(r_op, r_lane, r_rd);
      run_txn($sformatf("rnd%0d", i), r_op, {18'h0, 12'($urandom), r_lane}, 32'h0, r_rd,
              $urandom_range(1, 4), model_dr, 1'b0, 4'b1111, 32'h0);
    end

    // Reset while BUSY drops the request and clears the load register.
    m_valid = 1'b1; m_op = OP_LW; m_addr = 32'h0000_100C;
    step();
    reset = 1'b1; m_valid = 1'b0; m_op = OP_NONE;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy.req", 32'(bus_req), 32'd0);
    check("rst_busy.idle", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_busy.m_dr", m_dr, 32'd0);
    check("rst_busy.stall", 32'(stall), 32'd0);
    model_dr = 32'h0;
    step();

`ifdef LSU_TIMEOUT_EN
    // No ack: bus error after four BUSY cycles.
    exp_q.push_back(32'h0);
    m_valid = 1'b1; m_op = OP_LW; m_addr = 32'h0000_1010;
    step();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("tmo.req%0d", k), 32'(bus_req), 32'd1);
      step();
    end
    @(negedge clk);
    check("tmo.req_drop", 32'(bus_req), 32'd0);
    check("tmo.exc", 32'(exc), 32'd1);
    check("tmo.exc_code", 32'(exc_code), 32'(EXC_DBE));
    check("tmo.done", 32'(done), 32'd1);
    check("tmo.m_dr", m_dr, exp_q.pop_front());
    m_valid = 1'b0; m_op = OP_NONE;
    step();
    @(negedge clk);
    check("tmo.exc_clear", 32'(exc), 32'd0);
    step();
`endif

    check("sb.queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
